spin_fifo_multi_maintainer: RTL and testbench

Multi-channel successor to the single-channel spin FIFO maintainer. It holds NUM_CH independent spin FIFOs, each with its own completion-status register and its own flush. The channels feed one shared pop port through a round-robin arbiter. It sits between the spin producers (per-chain annealing update logic) and the flip manager / host readout path. It also adds per-channel completion-done pulses and full-resolution usage reporting.

---
 rtl/spin_fifo_multi_maintainer.sv | 155 +++++++++++++++
 tb/tb_spin_fifo_multi_maintainer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_fifo_multi_maintainer.sv
`default_nettype none
// ============================================================================
// spin_fifo_multi_maintainer : NUM_CH spin FIFOs with completion tracking and
// round-robin arbitration onto one shared pop port.          Revision: 1.0
// ============================================================================
module spin_fifo_multi_maintainer #(
  parameter int NUM_CH     = 4,
  parameter int SPIN_DEPTH = 2,
  parameter int DATASPIN   = 256,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int USAGE_W    = $clog2(SPIN_DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic [NUM_CH-1:0]           flush_i,
  input  logic [NUM_CH-1:0]           cmpt_en_i,
  input  logic [NUM_CH-1:0]           cmpt_stop_i,
  input  logic                        host_readout_i,
  input  logic                        spin_push_valid_i,
  input  logic [CH_W-1:0]             spin_push_ch_i,
  input  logic [DATASPIN-1:0]         spin_push_i,
  output logic                        spin_push_ready_o,
  output logic                        spin_pop_valid_o,
  output logic [DATASPIN-1:0]         spin_pop_o,
  output logic [CH_W-1:0]             spin_pop_ch_o,
  input  logic                        spin_pop_ready_i,
  output logic [NUM_CH-1:0]           cmpt_busy_o,
  output logic [NUM_CH-1:0]           cmpt_done_o,
  output logic [NUM_CH-1:0]           fifo_full_o,
  output logic [NUM_CH*USAGE_W-1:0]   fifo_usage_o
);

  localparam int PTR_W = (SPIN_DEPTH > 1) ? $clog2(SPIN_DEPTH) : 1;

  logic [DATASPIN-1:0] mem [NUM_CH][SPIN_DEPTH];
  logic [PTR_W-1:0]    rd_ptr [NUM_CH];
  logic [PTR_W-1:0]    wr_ptr [NUM_CH];
  logic [USAGE_W-1:0]  usage  [NUM_CH];

  logic [NUM_CH-1:0] full, empty, ch_hit, push_ch, pop_ch;
  logic [NUM_CH-1:0] elig, busy, done_q, done_d, grant_oh;
  logic [CH_W-1:0]   last_q, grant;
  logic              push_fire, pop_fire, any_elig;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SPIN_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // One-hot channel decode; an out-of-range channel index matches nothing.
  always_comb begin
    ch_hit = '0;
    full   = '0;
    empty  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c] = (spin_push_ch_i == CH_W'(c));
      full[c]   = (usage[c] == USAGE_W'(SPIN_DEPTH));
      empty[c]  = (usage[c] == '0);
    end
  end

  assign spin_push_ready_o = en_i & (|(ch_hit & ~full & ~flush_i));
  assign push_fire         = spin_push_valid_i & spin_push_ready_o;
  assign push_ch           = ch_hit & {NUM_CH{push_fire}};

  assign elig = {NUM_CH{en_i}} & ~empty & ~flush_i &
                ((busy & ~cmpt_stop_i) | {NUM_CH{host_readout_i}});
  assign any_elig = |elig;

  // Search starts one past the last granted channel.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant    = '0;
    grant_oh = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_q) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found         = 1'b1;
        grant         = CH_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    spin_pop_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_oh[c]) spin_pop_o = mem[c][rd_ptr[c]];
    end
  end

  assign spin_pop_valid_o = any_elig;
  assign spin_pop_ch_o    = grant;
  assign pop_fire         = any_elig & spin_pop_ready_i;
  assign pop_ch           = grant_oh & {NUM_CH{pop_fire}};

  always_comb begin
    done_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      done_d[c] = pop_ch[c] & (usage[c] == USAGE_W'(1)) & ~push_ch[c] &
                  busy[c] & ~flush_i[c];
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ch[c]) mem[c][wr_ptr[c]] <= spin_push_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        usage[c]  <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
      busy   <= '0;
      done_q <= '0;
      last_q <= CH_W'(NUM_CH - 1);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_i[c]) begin
          usage[c]  <= '0;
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
        end else begin
          if (push_ch[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
          if (pop_ch[c])  rd_ptr[c] <= ptr_inc(rd_ptr[c]);
          usage[c] <= usage[c] + USAGE_W'(push_ch[c]) - USAGE_W'(pop_ch[c]);
        end
        if (cmpt_stop_i[c] | flush_i[c])
          busy[c] <= 1'b0;
        else if (cmpt_en_i[c] & en_i)
          busy[c] <= 1'b1;
      end
      done_q <= done_d;
      if (pop_fire) last_q <= grant;
    end
  end

  assign cmpt_busy_o = busy;
  assign cmpt_done_o = done_q;
  assign fifo_full_o = full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_usage
    assign fifo_usage_o[c*USAGE_W +: USAGE_W] = usage[c];
  end

endmodule
`default_nettype wire

// File: tb/tb_spin_fifo_multi_maintainer.sv
`default_nettype none
// ============================================================================
// tb_spin_fifo_multi_maintainer : directed + random stimulus against a
// queue-based reference model.                                Revision: 1.0
// ============================================================================
module tb_spin_fifo_multi_maintainer;

  localparam int NUM_CH     = 4;
  localparam int SPIN_DEPTH = 2;
  localparam int DATASPIN   = 256;
  localparam int CH_W       = 2;
  localparam int USAGE_W    = 2;
  localparam int W          = DATASPIN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic                      en;
  logic [NUM_CH-1:0]         flush, cmpt_en, cmpt_stop;
  logic                      host, push_valid, pop_ready;
  logic [CH_W-1:0]           push_ch;
  logic [DATASPIN-1:0]       push_data;
  logic                      push_ready, pop_valid;
  logic [DATASPIN-1:0]       pop_data;
  logic [CH_W-1:0]           pop_ch;
  logic [NUM_CH-1:0]         busy_o, done_o, full_o;
  logic [NUM_CH*USAGE_W-1:0] usage_o;

  spin_fifo_multi_maintainer #(
    .NUM_CH(NUM_CH), .SPIN_DEPTH(SPIN_DEPTH), .DATASPIN(DATASPIN),
    .CH_W(CH_W), .USAGE_W(USAGE_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .cmpt_en_i(cmpt_en), .cmpt_stop_i(cmpt_stop), .host_readout_i(host),
    .spin_push_valid_i(push_valid), .spin_push_ch_i(push_ch),
    .spin_push_i(push_data), .spin_push_ready_o(push_ready),
    .spin_pop_valid_o(pop_valid), .spin_pop_o(pop_data),
    .spin_pop_ch_o(pop_ch), .spin_pop_ready_i(pop_ready),
    .cmpt_busy_o(busy_o), .cmpt_done_o(done_o), .fifo_full_o(full_o),
    .fifo_usage_o(usage_o)
  );

  int checks = 0;
  int errors = 0;

  logic [DATASPIN-1:0] mq [NUM_CH][$];
  logic [NUM_CH-1:0]   m_busy, m_done;
  int                  m_last;
  logic [DATASPIN-1:0] popped [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_busy = '0;
    m_done = '0;
    m_last = NUM_CH - 1;
  endtask

  function automatic bit elig_m(input int c);
    return en && (mq[c].size() > 0) && ((m_busy[c] && !cmpt_stop[c]) || host) && !flush[c];
  endfunction

  function automatic bit ready_m();
    int c;
    c = int'(push_ch);
    return en && (c < NUM_CH) && (mq[c].size() < SPIN_DEPTH) && !flush[c];
  endfunction

  task automatic model_grant(output bit v, output int g);
    v = 1'b0;
    g = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!v && elig_m((m_last + k) % NUM_CH)) begin
        v = 1'b1;
        g = (m_last + k) % NUM_CH;
      end
    end
  endtask

  task automatic check_now();
    bit v;
    int g;
    logic [NUM_CH-1:0]         ef;
    logic [NUM_CH*USAGE_W-1:0] eu;
    logic [DATASPIN-1:0]       ed;
    model_grant(v, g);
    ef = '0;
    eu = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c] = (mq[c].size() == SPIN_DEPTH);
      eu[c*USAGE_W +: USAGE_W] = USAGE_W'(mq[c].size());
    end
    ed = v ? mq[g][0] : '0;
    chk("push_ready", W'(push_ready), W'(ready_m()));
    chk("pop_valid",  W'(pop_valid),  W'(v));
    chk("pop_data",   pop_data,       ed);
    chk("pop_ch",     W'(pop_ch),     W'(v ? g : 0));
    chk("busy",       W'(busy_o),     W'(m_busy));
    chk("done",       W'(done_o),     W'(m_done));
    chk("full",       W'(full_o),     W'(ef));
    chk("usage",      W'(usage_o),    W'(eu));
  endtask

  // Checks at the negative edge, then advances the model by one clock.
  task automatic step();
    bit v, pf, hf;
    int g;
    logic [NUM_CH-1:0] nd;
    @(negedge clk);
    check_now();
    model_grant(v, g);
    hf = push_valid && ready_m();
    pf = v && pop_ready;
    if (pf) popped.push_back(pop_data);
    nd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nd[c] = pf && (g == c) && (mq[c].size() == 1) &&
              !(hf && (int'(push_ch) == c)) && m_busy[c] && !flush[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (flush[c]) mq[c].delete();
      else begin
        if (pf && g == c) void'(mq[c].pop_front());
        if (hf && int'(push_ch) == c) mq[c].push_back(push_data);
      end
      if (cmpt_stop[c] || flush[c]) m_busy[c] = 1'b0;
      else if (cmpt_en[c] && en)    m_busy[c] = 1'b1;
    end
    if (pf) m_last = g;
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    flush = '0; cmpt_en = '0; cmpt_stop = '0; host = 1'b0;
    push_valid = 1'b0; push_ch = '0; push_data = '0; pop_ready = 1'b0;
  endtask

  task automatic do_push(input int c, input logic [DATASPIN-1:0] d);
    push_valid = 1'b1;
    push_ch    = CH_W'(c);
    push_data  = d;
    step();
    push_valid = 1'b0;
  endtask

  function automatic logic [DATASPIN-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  localparam logic [DATASPIN-1:0] WA = W'(64'hA000_0000_0000_00A1);
  localparam logic [DATASPIN-1:0] WB = W'(64'hB000_0000_0000_00B2);
  localparam logic [DATASPIN-1:0] WC = W'(64'hC000_0000_0000_00C3);

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    defaults();
    model_reset();
    #2;
    check_now();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // A, B to ch0, C to ch1, then drain: expect A, C, B
    en = 1'b1;
    do_push(0, WA);
    do_push(0, WB);
    cmpt_en = 4'b0011;
    do_push(1, WC);
    cmpt_en = '0;
    popped.delete();
    pop_ready = 1'b1;
    repeat (4) step();
    pop_ready = 1'b0;
    chk("pop_count", W'(popped.size()), W'(3));
    if (popped.size() == 3) begin
      chk("pop0_A", popped[0], WA);
      chk("pop1_C", popped[1], WC);
      chk("pop2_B", popped[2], WB);
    end

    // Fill ch2 and check backpressure is per channel
    do_push(2, rand_word());
    do_push(2, rand_word());
    chk("full2", W'(full_o[2]), W'(1));
    push_valid = 1'b1; push_ch = 2'd2;
    #1 chk("ready_ch2_full", W'(push_ready), W'(0));
    push_ch = 2'd3;
    #1 chk("ready_ch3", W'(push_ready), W'(1));
    push_valid = 1'b0;
    cmpt_en = 4'b0100;
    step();
    cmpt_en = '0;
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    push_valid = 1'b1; push_ch = 2'd2;
    #1 chk("ready_ch2_after_pop", W'(push_ready), W'(1));
    push_valid = 1'b0;
    pop_ready = 1'b1;
    repeat (2) step();
    pop_ready = 1'b0;

    // Stop on a busy channel, then host readout drains it
    do_push(3, rand_word());
    do_push(3, rand_word());
    cmpt_en = 4'b1000;
    step();
    cmpt_en = '0;
    step();
    chk("valid_ch3_busy", W'(pop_valid), W'(1));
    cmpt_stop = 4'b1000;
    #1 chk("valid_stop_comb", W'(pop_valid), W'(0));
    step();
    cmpt_stop = '0;
    chk("busy3_cleared", W'(busy_o[3]), W'(0));
    chk("usage3_kept", W'(usage_o[3*USAGE_W +: USAGE_W]), W'(2));
    host = 1'b1; pop_ready = 1'b1;
    repeat (3) step();
    host = 1'b0; pop_ready = 1'b0;
    chk("usage3_drained", W'(usage_o[3*USAGE_W +: USAGE_W]), W'(0));

    // Arm and clear together: clear wins
    cmpt_en = 4'b0010; cmpt_stop = 4'b0010;
    step();
    defaults();
    chk("busy1_clear_wins", W'(busy_o[1]), W'(0));

    // Flush with a same-cycle push to the flushed channel
    do_push(1, rand_word());
    flush = 4'b0010; push_valid = 1'b1; push_ch = 2'd1; push_data = rand_word();
    #1 chk("ready_flush", W'(push_ready), W'(0));
    step();
    defaults();
    chk("usage1_flushed", W'(usage_o[1*USAGE_W +: USAGE_W]), W'(0));

    // Simultaneous push and pop at usage 1
    cmpt_en = 4'b0001;
    do_push(0, rand_word());
    cmpt_en = '0;
    push_valid = 1'b1; push_ch = 2'd0; push_data = rand_word(); pop_ready = 1'b1;
    step();
    push_valid = 1'b0; pop_ready = 1'b0;
    chk("usage0_pushpop", W'(usage_o[1:0]), W'(1));
    chk("done0_none", W'(done_o[0]), W'(0));
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(15) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        flush[c]     = ($urandom_range(31) == 0);
        cmpt_en[c]   = ($urandom_range(3) == 0);
        cmpt_stop[c] = ($urandom_range(15) == 0);
      end
      host       = ($urandom_range(7) == 0);
      push_valid = ($urandom_range(1) == 0);
      push_ch    = CH_W'($urandom_range(NUM_CH - 1));
      push_data  = rand_word();
      pop_ready  = ($urandom_range(3) != 0);
      step();
    end

    // Asynchronous reset in the middle of traffic
    defaults();
    en = 1'b1;
    do_push(2, rand_word());
    push_valid = 1'b1; push_ch = 2'd2; push_data = rand_word();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now();
    chk("usage_async_rst", W'(usage_o), W'(0));
    push_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
